// File: rtl/multicycle_control.sv
// Multi-cycle RV64 control unit: sequences FETCH/DECODE/EXEC/MEM/WB,
// drives datapath strobes and counts retired instructions.
module multicycle_control #(
  parameter bit ENABLE_W    = 1'b1,
  parameter bit ENABLE_JUMP = 1'b1,
  parameter bit TRAP_HALT   = 1'b1,
  parameter int CNT_W       = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [6:0]       opcode_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             ir_write_o,
  output logic             pc_inc_o,
  output logic             branch_o,
  output logic             pc_load_o,
  output logic             reg_write_o,
  output logic [1:0]       alu_op_o,
  output logic [1:0]       alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [1:0]       result_src_o,
  output logic             word_op_o,
  output logic             illegal_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] instret_o
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_RW    = 7'b0111011;
  localparam logic [6:0] OP_IW    = 7'b0011011;

  state_e           state_q;
  logic [6:0]       opcode_q;
  logic [CNT_W-1:0] instret_q;
  logic             mem_req;

  function automatic logic legal(input logic [6:0] op);
    legal = (op == OP_R) || (op == OP_I) || (op == OP_LD) ||
            (op == OP_ST) || (op == OP_BR) || (op == OP_LUI) ||
            (op == OP_AUIPC) ||
            (ENABLE_W && ((op == OP_RW) || (op == OP_IW))) ||
            (ENABLE_JUMP && ((op == OP_JAL) || (op == OP_JALR)));
  endfunction

  logic is_r, is_i, is_ld, is_st, is_br;
  logic is_lui, is_auipc, is_jal, is_jalr, is_w;

  assign is_r     = (opcode_q == OP_R);
  assign is_i     = (opcode_q == OP_I);
  assign is_ld    = (opcode_q == OP_LD);
  assign is_st    = (opcode_q == OP_ST);
  assign is_br    = (opcode_q == OP_BR);
  assign is_lui   = (opcode_q == OP_LUI);
  assign is_auipc = (opcode_q == OP_AUIPC);
  assign is_jal   = ENABLE_JUMP && (opcode_q == OP_JAL);
  assign is_jalr  = ENABLE_JUMP && (opcode_q == OP_JALR);
  assign is_w     = ENABLE_W &&
                    ((opcode_q == OP_RW) || (opcode_q == OP_IW));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_RESET;
      opcode_q  <= '0;
      instret_q <= '0;
    end else begin
      case (state_q)
        S_RESET: state_q <= S_FETCH;
        S_FETCH: if (mem_ready_i) state_q <= S_DECODE;
        S_DECODE: begin
          opcode_q <= opcode_i;
          state_q  <= legal(opcode_i) ? S_EXEC : S_TRAP;
        end
        S_EXEC: begin
          if (is_ld || is_st) begin
            state_q <= S_MEM;
          end else if (is_br) begin
            state_q   <= S_FETCH;
            instret_q <= instret_q + CNT_W'(1);
          end else begin
            state_q <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready_i) begin
            if (is_st) begin
              state_q   <= S_FETCH;
              instret_q <= instret_q + CNT_W'(1);
            end else begin
              state_q <= S_WB;
            end
          end
        end
        S_WB: begin
          state_q   <= S_FETCH;
          instret_q <= instret_q + CNT_W'(1);
        end
        S_TRAP: if (!TRAP_HALT) state_q <= S_FETCH;
        default: state_q <= S_RESET;
      endcase
    end
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we_o     = 1'b0;
    ir_write_o   = 1'b0;
    pc_inc_o     = 1'b0;
    branch_o     = 1'b0;
    pc_load_o    = 1'b0;
    reg_write_o  = 1'b0;
    alu_op_o     = 2'b00;
    alu_src_a_o  = 2'b00;
    alu_src_b_o  = 2'b00;
    result_src_o = 2'b00;
    word_op_o    = 1'b0;
    illegal_o    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        ir_write_o = mem_ready_i;
        pc_inc_o   = mem_ready_i;
      end
      S_EXEC: begin
        word_op_o = is_w;
        unique case (1'b1)
          is_r || (is_w && opcode_q == OP_RW): alu_op_o = 2'b10;
          is_i || (is_w && opcode_q == OP_IW): begin
            alu_op_o    = 2'b10;
            alu_src_b_o = 2'b01;
          end
          is_ld || is_st: alu_src_b_o = 2'b01;
          is_br: begin
            alu_op_o = 2'b01;
            branch_o = 1'b1;
          end
          is_lui: begin
            alu_op_o    = 2'b11;
            alu_src_b_o = 2'b01;
          end
          is_auipc, is_jal: begin
            alu_src_a_o = 2'b01;
            alu_src_b_o = 2'b01;
            pc_load_o   = is_jal;
          end
          is_jalr: begin
            alu_src_b_o = 2'b01;
            pc_load_o   = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we_o = is_st;
      end
      S_WB: begin
        reg_write_o = 1'b1;
        word_op_o   = is_w;
        if (is_ld)
          result_src_o = 2'b01;
        else if (is_jal || is_jalr)
          result_src_o = 2'b10;
      end
      S_TRAP: illegal_o = 1'b1;
      default: ;
    endcase
  end

  // A reset cycle withdraws any outstanding memory request immediately
  assign mem_req_o = mem_req & ~rst_i;
  assign state_o   = state_q;
  assign instret_o = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: two parameterisations driven
// through per-instruction expected traces built from opcode classes.
module tb_multicycle_control;

  typedef struct packed {
    logic [2:0]  st;
    logic        req, we, irw, pci, br, pcl, rw;
    logic [1:0]  aop, sa, sb, rs;
    logic        wop, ill;
    logic [63:0] ir;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1;
  logic       rst_b = 1'b1;
  logic [6:0] opcode = '0;
  logic       mem_ready = 1'b0;
  bit         sel = 1'b0;

  logic a_req, a_we, a_irw, a_pci, a_br, a_pcl, a_rw, a_wop, a_ill;
  logic [1:0] a_aop, a_sa, a_sb, a_rs;
  logic [2:0] a_st;
  logic [63:0] a_ir;
  logic b_req, b_we, b_irw, b_pci, b_br, b_pcl, b_rw, b_wop, b_ill;
  logic [1:0] b_aop, b_sa, b_sb, b_rs;
  logic [2:0] b_st;
  logic [3:0] b_ir;

  multicycle_control #(
    .ENABLE_W(1'b1), .ENABLE_JUMP(1'b1), .TRAP_HALT(1'b1), .CNT_W(64)
  ) dut_a (
    .clk_i(clk), .rst_i(rst_a), .opcode_i(opcode),
    .mem_ready_i(mem_ready), .mem_req_o(a_req), .mem_we_o(a_we),
    .ir_write_o(a_irw), .pc_inc_o(a_pci), .branch_o(a_br),
    .pc_load_o(a_pcl), .reg_write_o(a_rw), .alu_op_o(a_aop),
    .alu_src_a_o(a_sa), .alu_src_b_o(a_sb), .result_src_o(a_rs),
    .word_op_o(a_wop), .illegal_o(a_ill), .state_o(a_st),
    .instret_o(a_ir)
  );

  multicycle_control #(
    .ENABLE_W(1'b0), .ENABLE_JUMP(1'b0), .TRAP_HALT(1'b0), .CNT_W(4)
  ) dut_b (
    .clk_i(clk), .rst_i(rst_b), .opcode_i(opcode),
    .mem_ready_i(mem_ready), .mem_req_o(b_req), .mem_we_o(b_we),
    .ir_write_o(b_irw), .pc_inc_o(b_pci), .branch_o(b_br),
    .pc_load_o(b_pcl), .reg_write_o(b_rw), .alu_op_o(b_aop),
    .alu_src_a_o(b_sa), .alu_src_b_o(b_sb), .result_src_o(b_rs),
    .word_op_o(b_wop), .illegal_o(b_ill), .state_o(b_st),
    .instret_o(b_ir)
  );

  obs_t got;
  always_comb begin
    if (sel)
      got = {b_st, b_req, b_we, b_irw, b_pci, b_br, b_pcl, b_rw,
             b_aop, b_sa, b_sb, b_rs, b_wop, b_ill, {60'b0, b_ir}};
    else
      got = {a_st, a_req, a_we, a_irw, a_pci, a_br, a_pcl, a_rw,
             a_aop, a_sa, a_sb, a_rs, a_wop, a_ill, a_ir};
  end

  bit          ew, ej, th;
  int          cw;
  logic [63:0] cnt;
  int          ncmp = 0;
  int          nfail = 0;

  function automatic logic [63:0] mask();
    logic [63:0] one = 64'd1;
    return (cw >= 64) ? '1 : ((one << cw) - 64'd1);
  endfunction

  // Instruction classes: 0 R, 1 I, 2 LD, 3 ST, 4 BR, 5 LUI,
  // 6 AUIPC, 7 JAL, 8 JALR, 9 OP-32, 10 OP-IMM-32, -1 illegal
  function automatic int cls(input logic [6:0] op);
    case (op)
      7'b0110011: return 0;
      7'b0010011: return 1;
      7'b0000011: return 2;
      7'b0100011: return 3;
      7'b1100011: return 4;
      7'b0110111: return 5;
      7'b0010111: return 6;
      7'b1101111: return ej ? 7 : -1;
      7'b1100111: return ej ? 8 : -1;
      7'b0111011: return ew ? 9 : -1;
      7'b0011011: return ew ? 10 : -1;
      default:    return -1;
    endcase
  endfunction

  function automatic obs_t base(input logic [2:0] st);
    obs_t e = '0;
    e.st = st;
    e.ir = cnt & mask();
    return e;
  endfunction

  function automatic obs_t exec_obs(input int c);
    obs_t e = base(3'd3);
    case (c)
      0, 9:  e.aop = 2'b10;
      1, 10: begin e.aop = 2'b10; e.sb = 2'b01; end
      2, 3:  e.sb = 2'b01;
      4:     begin e.aop = 2'b01; e.br = 1'b1; end
      5:     begin e.aop = 2'b11; e.sb = 2'b01; end
      6:     begin e.sa = 2'b01; e.sb = 2'b01; end
      7:     begin e.sa = 2'b01; e.sb = 2'b01; e.pcl = 1'b1; end
      8:     begin e.sb = 2'b01; e.pcl = 1'b1; end
      default: ;
    endcase
    e.wop = (c >= 9);
    return e;
  endfunction

  task automatic chk(input obs_t e, input logic mr, input string tag);
    @(negedge clk);
    mem_ready = mr;
    #1;
    ncmp++;
    assert (got === e) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, got, e);
    end
  endtask

  task automatic do_reset();
    if (sel) rst_b = 1'b1; else rst_a = 1'b1;
    cnt = '0;
    chk(base(3'd0), 1'b0, "reset_hold");
    chk(base(3'd0), 1'b1, "reset");
    if (sel) rst_b = 1'b0; else rst_a = 1'b0;
  endtask

  task automatic run_instr(input logic [6:0] op, input int fw,
                           input int mw);
    int   c;
    obs_t e;
    c = cls(op);
    opcode = op;
    for (int i = 0; i < fw; i++) begin
      e = base(3'd1); e.req = 1'b1;
      chk(e, 1'b0, "fetch_wait");
    end
    e = base(3'd1); e.req = 1'b1; e.irw = 1'b1; e.pci = 1'b1;
    chk(e, 1'b1, "fetch");
    chk(base(3'd2), 1'($urandom_range(0, 1)), "decode");
    if (c < 0) begin
      e = base(3'd6); e.ill = 1'b1;
      for (int i = 0; i < (th ? 10 : 1); i++)
        chk(e, 1'($urandom_range(0, 1)), "trap");
      return;
    end
    chk(exec_obs(c), 1'($urandom_range(0, 1)), "exec");
    if (c == 4) begin
      cnt = cnt + 64'd1;
      return;
    end
    if (c == 2 || c == 3) begin
      e = base(3'd4); e.req = 1'b1; e.we = (c == 3);
      for (int i = 0; i < mw; i++) chk(e, 1'b0, "mem_wait");
      chk(e, 1'b1, "mem");
      if (c == 3) begin
        cnt = cnt + 64'd1;
        return;
      end
    end
    e = base(3'd5); e.rw = 1'b1; e.wop = (c >= 9);
    e.rs = (c == 2) ? 2'b01 : ((c == 7 || c == 8) ? 2'b10 : 2'b00);
    chk(e, 1'($urandom_range(0, 1)), "wb");
    cnt = cnt + 64'd1;
  endtask

  logic [6:0] ops [0:10] = '{
    7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
    7'b0110111, 7'b0010111, 7'b0111011, 7'b0011011, 7'b1101111,
    7'b1100111
  };

  initial begin
    obs_t e;
    logic [6:0] rop;
    // Configuration A: W and jumps enabled, halting trap, 64-bit counter
    sel = 1'b0; ew = 1'b1; ej = 1'b1; th = 1'b1; cw = 64; cnt = '0;
    do_reset();
    run_instr(7'b0110011, 0, 0);
    run_instr(7'b0000011, 0, 2);
    run_instr(7'b0100011, 1, 0);
    run_instr(7'b1100011, 0, 0);
    run_instr(7'b0111011, 0, 0);
    run_instr(7'b0011011, 2, 0);
    run_instr(7'b1101111, 0, 0);
    run_instr(7'b1100111, 0, 0);
    run_instr(7'b0110111, 0, 0);
    run_instr(7'b0010111, 0, 0);
    for (int i = 0; i < 40; i++)
      run_instr(ops[$urandom_range(0, 10)], $urandom_range(0, 2),
                $urandom_range(0, 2));
    // Load interrupted by reset while waiting in MEM
    run_instr(7'b0110011, 0, 0);
    opcode = 7'b0000011;
    e = base(3'd1); e.req = 1'b1; e.irw = 1'b1; e.pci = 1'b1;
    chk(e, 1'b1, "ld_fetch");
    chk(base(3'd2), 1'b0, "ld_decode");
    chk(exec_obs(2), 1'b0, "ld_exec");
    e = base(3'd4); e.req = 1'b1;
    chk(e, 1'b0, "ld_mem");
    @(negedge clk);
    rst_a = 1'b1;
    mem_ready = 1'b0;
    #1;
    e = base(3'd4);
    ncmp++;
    assert (got === e) else begin
      nfail++;
      $error("FAIL rst_in_mem: observed %h expected %h", got, e);
    end
    cnt = '0;
    chk(base(3'd0), 1'b0, "rst_to_reset");
    rst_a = 1'b0;
    run_instr(7'b0110011, 0, 0);
    run_instr(7'b0000000, 0, 0);
    do_reset();
    // Configuration B: W and jumps illegal, one-cycle trap, 4-bit counter
    rst_a = 1'b1;
    sel = 1'b1; ew = 1'b0; ej = 1'b0; th = 1'b0; cw = 4; cnt = '0;
    do_reset();
    run_instr(7'b0111011, 0, 0);
    run_instr(7'b1101111, 0, 0);
    run_instr(7'b0000000, 1, 0);
    run_instr(7'b0110011, 0, 0);
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 12))
        11:      rop = 7'b0000000;
        12:      rop = 7'($urandom);
        default: rop = ops[$urandom_range(0, 10)];
      endcase
      run_instr(rop, $urandom_range(0, 2), $urandom_range(0, 2));
    end
    for (int i = 0; i < 17; i++)
      run_instr(ops[$urandom_range(0, 6)], 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
